// File: rtl/food_placer.sv
// Food placement FSM: samples random coordinates, checks occupancy, latches the first free cell.
// Define FOOD_FALLBACK_SCAN_EN to fall back to a raster scan of the grid when random tries run out.
module food_placer #(
   parameter int X_MAX     = 160,
   parameter int Y_MAX     = 120,
   parameter int MAX_TRIES = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       place_req,
   input  logic [7:0] rand_x,
   input  logic [6:0] rand_y,
   output logic       rand_en,
   output logic [7:0] occ_x,
   output logic [6:0] occ_y,
   input  logic       occ_hit,
   output logic [7:0] food_x,
   output logic [6:0] food_y,
   output logic       food_valid,
   output logic       busy,
   output logic       fail
);

   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam logic [TW-1:0] TRY_LIM = TW'(MAX_TRIES);
   localparam logic [8:0]    X_LIM   = 9'(X_MAX);
   localparam logic [7:0]    Y_LIM   = 8'(Y_MAX);
`ifdef FOOD_FALLBACK_SCAN_EN
   localparam logic [7:0]    X_LAST  = 8'(X_MAX - 1);
   localparam logic [6:0]    Y_LAST  = 7'(Y_MAX - 1);
`endif

   typedef enum logic [1:0] {
      IDLE,
      SAMPLE,
      CHECK
`ifdef FOOD_FALLBACK_SCAN_EN
      , SCAN
`endif
   } state_t;

   state_t          state;
   logic [TW-1:0]   tries;
   logic [TW-1:0]   tries_nxt;
   logic            oob;
   logic            try_used;
   logic            exhausted;
`ifdef FOOD_FALLBACK_SCAN_EN
   logic            scan_chk;
`endif

   // A try is consumed by an out-of-bounds sample or an occupied lookup.
   always_comb begin
      tries_nxt = tries + 1'b1;
      oob       = ({1'b0, rand_x} >= X_LIM) || ({1'b0, rand_y} >= Y_LIM);
      try_used  = ((state == SAMPLE) && oob) || ((state == CHECK) && occ_hit);
      exhausted = try_used && (tries_nxt == TRY_LIM);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         tries      <= '0;
         occ_x      <= '0;
         occ_y      <= '0;
         food_x     <= '0;
         food_y     <= '0;
         food_valid <= 1'b0;
         busy       <= 1'b0;
         fail       <= 1'b0;
         rand_en    <= 1'b0;
`ifdef FOOD_FALLBACK_SCAN_EN
         scan_chk   <= 1'b0;
`endif
      end else begin
         fail <= 1'b0;
         if (try_used)
            tries <= tries_nxt;
         if (exhausted) begin
            rand_en <= 1'b0;
`ifdef FOOD_FALLBACK_SCAN_EN
            state    <= SCAN;
            scan_chk <= 1'b0;
            occ_x    <= '0;
            occ_y    <= '0;
`else
            state <= IDLE;
            busy  <= 1'b0;
            fail  <= 1'b1;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (place_req) begin
                     food_valid <= 1'b0;
                     tries      <= '0;
                     state      <= SAMPLE;
                     rand_en    <= 1'b1;
                     busy       <= 1'b1;
                  end
               end
               SAMPLE: begin
                  // Out-of-bounds samples stay here with rand_en still high.
                  if (!oob) begin
                     occ_x   <= rand_x;
                     occ_y   <= rand_y;
                     rand_en <= 1'b0;
                     state   <= CHECK;
                  end
               end
               CHECK: begin
                  if (!occ_hit) begin
                     food_x     <= occ_x;
                     food_y     <= occ_y;
                     food_valid <= 1'b1;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     rand_en <= 1'b1;
                     state   <= SAMPLE;
                  end
               end
`ifdef FOOD_FALLBACK_SCAN_EN
               SCAN: begin
                  // Address cycle, then evaluate cycle: one lookup per two clocks.
                  if (!scan_chk) begin
                     scan_chk <= 1'b1;
                  end else if (!occ_hit) begin
                     food_x     <= occ_x;
                     food_y     <= occ_y;
                     food_valid <= 1'b1;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end else if ((occ_x == X_LAST) && (occ_y == Y_LAST)) begin
                     fail  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     scan_chk <= 1'b0;
                     if (occ_x == X_LAST) begin
                        occ_x <= '0;
                        occ_y <= occ_y + 1'b1;
                     end else begin
                        occ_x <= occ_x + 1'b1;
                     end
                  end
               end
`endif
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: directed scenarios plus randomized requests checked against a grid model.
module tb_food_placer;
   localparam int X_MAX     = 160;
   localparam int Y_MAX     = 120;
   localparam int MAX_TRIES = 16;
   localparam int LIMIT     = 40000;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       place_req = 1'b0;
   logic [7:0] rand_x = '0;
   logic [6:0] rand_y = '0;
   logic       rand_en;
   logic [7:0] occ_x;
   logic [6:0] occ_y;
   logic       occ_hit;
   logic [7:0] food_x;
   logic [6:0] food_y;
   logic       food_valid;
   logic       busy;
   logic       fail;

   food_placer #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .MAX_TRIES(MAX_TRIES)) dut (
      .clk(clk), .resetn(resetn), .place_req(place_req),
      .rand_x(rand_x), .rand_y(rand_y), .rand_en(rand_en),
      .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit),
      .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
      .busy(busy), .fail(fail)
   );

   always #5 clk = ~clk;

   // occupancy grid answered combinationally from the lookup address
   bit occ_map [0:Y_MAX-1][0:X_MAX-1];
   always_comb begin
      occ_hit = 1'b0;
      if (int'(occ_x) < X_MAX && int'(occ_y) < Y_MAX)
         occ_hit = occ_map[occ_y][occ_x];
   end

   // coordinate generator: next queued sample whenever the strobe is up
   logic [14:0] samp_q[$];
   always @(negedge clk) begin
      if (rand_en) begin
         if (samp_q.size() > 0) {rand_x, rand_y} = samp_q.pop_front();
         else {rand_x, rand_y} = 15'd0;
      end
   end

   int n_checks = 0;
   int n_fails  = 0;
   int sx [MAX_TRIES];
   int sy [MAX_TRIES];
   int last_fx = 0;
   int last_fy = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_map(input bit v);
      for (int y = 0; y < Y_MAX; y++)
         for (int x = 0; x < X_MAX; x++)
            occ_map[y][x] = v;
   endtask

   task automatic rand_samples(input int min_y);
      for (int i = 0; i < MAX_TRIES; i++) begin
         sx[i] = $urandom_range(0, X_MAX - 1);
         sy[i] = $urandom_range(min_y, Y_MAX - 1);
      end
   endtask

   // Outcome and cycle count from request to result: one cycle to accept, one per
   // out-of-range sample, two per lookup, two per scanned cell.
   task automatic model_req(output bit ok, output int ex, output int ey, output int ecyc);
      int cost;
      cost = 1; ok = 1'b0; ex = 0; ey = 0;
      for (int i = 0; i < MAX_TRIES && !ok; i++) begin
         if (sx[i] >= X_MAX || sy[i] >= Y_MAX) cost += 1;
         else if (occ_map[sy[i]][sx[i]]) cost += 2;
         else begin ok = 1'b1; ex = sx[i]; ey = sy[i]; cost += 2; end
      end
`ifdef FOOD_FALLBACK_SCAN_EN
      for (int c = 0; c < X_MAX * Y_MAX && !ok; c++) begin
         cost += 2;
         if (!occ_map[c / X_MAX][c % X_MAX]) begin
            ok = 1'b1; ex = c % X_MAX; ey = c / X_MAX;
         end
      end
`endif
      ecyc = cost;
   endtask

   task automatic run_req(input string nm, input bit poke);
      bit eok;
      int ex, ey, ecyc, cyc;
      model_req(eok, ex, ey, ecyc);
      samp_q.delete();
      for (int i = 0; i < MAX_TRIES; i++) samp_q.push_back({8'(sx[i]), 7'(sy[i])});
      @(negedge clk);
      place_req = 1'b1;
      @(negedge clk);
      place_req = poke;
      cyc = 1;
      check_val({nm, "_acc_valid"}, food_valid, 0);
      check_val({nm, "_acc_busy"}, busy, 1);
      while (!food_valid && !fail && cyc < LIMIT) begin
         @(negedge clk);
         place_req = 1'b0;
         cyc++;
      end
      check_val({nm, "_done"}, cyc < LIMIT, 1);
      check_val({nm, "_latency"}, cyc, ecyc);
      check_val({nm, "_fail"}, fail, !eok);
      check_val({nm, "_valid"}, food_valid, eok);
      check_val({nm, "_busy"}, busy, 0);
      if (eok) begin last_fx = ex; last_fy = ey; end
      check_val({nm, "_fx"}, food_x, last_fx);
      check_val({nm, "_fy"}, food_y, last_fy);
      @(negedge clk);
      check_val({nm, "_fail_pulse"}, fail, 0);
      check_val({nm, "_valid_hold"}, food_valid, eok);
      check_val({nm, "_idle"}, busy, 0);
   endtask

   task automatic check_all_zero(input string nm);
      check_val({nm, "_rand_en"}, rand_en, 0);
      check_val({nm, "_occ_x"}, occ_x, 0);
      check_val({nm, "_occ_y"}, occ_y, 0);
      check_val({nm, "_food_x"}, food_x, 0);
      check_val({nm, "_food_y"}, food_y, 0);
      check_val({nm, "_valid"}, food_valid, 0);
      check_val({nm, "_busy"}, busy, 0);
      check_val({nm, "_fail"}, fail, 0);
   endtask

   initial begin
      set_map(1'b0);
      #1 resetn = 1'b0;
      #2 check_all_zero("reset");
      @(negedge clk);
      resetn = 1'b1;

      // best case, with a stray request while busy
      rand_samples(0);
      sx[0] = 10; sy[0] = 20;
      run_req("first_free", 1'b1);

      // one out-of-range sample first
      rand_samples(0);
      sx[0] = 200; sy[0] = 5; sx[1] = 30; sy[1] = 40;
      run_req("oob_retry", 1'b0);

      // y out of range also costs a try
      rand_samples(0);
      sx[0] = 7; sy[0] = 125; sx[1] = 159; sy[1] = 119;
      run_req("oob_y", 1'b0);

      // three occupied cells before a free one
      set_map(1'b0);
      rand_samples(0);
      for (int i = 0; i < 4; i++) begin sx[i] = 11 + i; sy[i] = 3 + i; end
      for (int i = 0; i < 3; i++) occ_map[sy[i]][sx[i]] = 1'b1;
      run_req("three_hits", 1'b0);

      // everything occupied except (2,1), which random samples avoid
      set_map(1'b1);
      occ_map[1][2] = 1'b0;
      rand_samples(2);
      run_req("exhaust", 1'b0);

      // reset while a lookup is in flight
      set_map(1'b0);
      rand_samples(0);
      sx[0] = 50; sy[0] = 60;
      samp_q.delete();
      for (int i = 0; i < MAX_TRIES; i++) samp_q.push_back({8'(sx[i]), 7'(sy[i])});
      @(negedge clk);
      place_req = 1'b1;
      @(negedge clk);
      place_req = 1'b0;
      @(negedge clk);
      check_val("mid_busy", busy, 1);
      #1 resetn = 1'b0;
      #1 check_all_zero("mid_reset");
      @(negedge clk);
      resetn = 1'b1;
      last_fx = 0; last_fy = 0;
      rand_samples(0);
      run_req("after_reset", 1'b0);

      // randomized requests against a sparse random grid
      set_map(1'b0);
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < MAX_TRIES; i++) begin
            sx[i] = $urandom_range(0, 255);
            sy[i] = $urandom_range(0, 127);
            if (sx[i] < X_MAX && sy[i] < Y_MAX)
               occ_map[sy[i]][sx[i]] = ($urandom_range(0, 99) < 75);
         end
         run_req($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/food_placer.md
FOOD_PLACER -- requirements
Module: food_placer

Interface
- REQ-001 SHALL have parameter X_MAX, default 160: exclusive upper bound on legal X.
- REQ-002 SHALL have parameter Y_MAX, default 120: exclusive upper bound on legal Y.
- REQ-003 SHALL have parameter MAX_TRIES, default 16: random samples allowed per request.
- REQ-004 SHALL have port clk  input  1  sole clock, all logic on its rising edge.
- REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
- REQ-006 SHALL have port place_req  input  1  start placement; sampled only in IDLE.
- REQ-007 SHALL have port rand_x  input  8  random X from the coordinate generator.
- REQ-008 SHALL have port rand_y  input  7  random Y from the coordinate generator.
- REQ-009 SHALL have port rand_en  output  1  capture strobe to the generator.
- REQ-010 SHALL have port occ_x  output  8  occupancy-lookup X.
- REQ-011 SHALL have port occ_y  output  7  occupancy-lookup Y.
- REQ-012 SHALL have port occ_hit  input  1  cell occupied, valid one cycle after occ_x/occ_y are driven.
- REQ-013 SHALL have port food_x  output  8  placed food X.
- REQ-014 SHALL have port food_y  output  7  placed food Y.
- REQ-015 SHALL have port food_valid  output  1  food_x/food_y hold a placed, unoccupied cell.
- REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
- REQ-017 SHALL have port fail  output  1  one-cycle pulse when placement gives up.

Function
- REQ-018 SHALL implement states IDLE, SAMPLE, CHECK and SCAN; SCAN exists only under REQ-031.
- REQ-019 In IDLE with place_req=1, SHALL clear food_valid, set try count to 0 and enter SAMPLE next cycle.
- REQ-020 In SAMPLE, SHALL assert rand_en for that cycle and capture rand_x/rand_y at its end.
- REQ-021 In SAMPLE, a captured sample with x>=X_MAX or y>=Y_MAX SHALL count as one try and remain in SAMPLE; no occupancy lookup is issued for it.
- REQ-022 In SAMPLE, an in-bounds sample SHALL drive occ_x/occ_y registered from the next cycle and enter CHECK.
- REQ-023 In CHECK with occ_hit=0, SHALL load food_x/food_y from the sample, set food_valid=1 and return to IDLE.
- REQ-024 In CHECK with occ_hit=1, SHALL count one try and return to SAMPLE.
- REQ-025 When the try count reaches MAX_TRIES, SHALL take the exhaustion path of REQ-031 instead of returning to SAMPLE.
- REQ-026 The try counter SHALL be wide enough to hold MAX_TRIES and SHALL never wrap.
- REQ-027 place_req SHALL be ignored while busy=1.
- REQ-028 Best-case latency from place_req to food_valid SHALL be 3 cycles: IDLE->SAMPLE->CHECK->IDLE with food_valid set.
- REQ-029 food_valid SHALL remain high until the next accepted place_req; food_x/food_y SHALL change only on a successful placement.

Reset
- REQ-030 resetn=0 SHALL immediately force IDLE, try count 0, food_x=0, food_y=0, occ_x=0, occ_y=0, and food_valid, busy, fail and rand_en all 0, including mid-placement; the block SHALL resume on the first clk edge after resetn rises.

Configuration
- REQ-031 Macro FOOD_FALLBACK_SCAN_EN: defined -> on exhaustion, enter SCAN and walk cells in raster order from (0,0) (x fastest, wrapping at X_MAX-1 into y+1), one lookup per 2 cycles, placing food at the first cell with occ_hit=0; fail SHALL pulse only if all X_MAX*Y_MAX cells are occupied. Undefined -> on exhaustion, pulse fail for one cycle, leave food_valid=0 and return to IDLE.

Verification
- REQ-032 Request with rand=(10,20) and occ_hit=0 -> food=(10,20), food_valid 3 cycles after place_req, fail=0.
- REQ-033 Request with rand=(200,5), then (30,40) and occ_hit=0 -> one try consumed, food=(30,40).
- REQ-034 occ_hit=1 for the first 3 lookups, then 0 -> food equals the 4th in-bounds sample.
- REQ-035 occ_hit always 1 without the macro -> fail pulses exactly once after 16 tries, food_valid=0, busy=0.
- REQ-036 With the macro, all lookups return 1 except at cell (2,1) -> food=(2,1) and fail=0.
- REQ-037 resetn pulsed low while in CHECK -> all outputs zero at once, and a new request afterwards completes normally.
